// File: rtl/gate_net_pkg.sv
// Shared types and helpers for the runtime-programmable gate-network classifier.
package gate_net_pkg;

  // Per-gate two-input function selected by the top three bits of a config word.
  typedef enum logic [2:0] {
    OpConst0 = 3'd0,
    OpConst1 = 3'd1,
    OpAnd    = 3'd2,
    OpOr     = 3'd3,
    OpXor    = 3'd4,
    OpNand   = 3'd5,
    OpNor    = 3'd6,
    OpPassA  = 3'd7
  } gate_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StScore,
    StDone
  } gn_state_e;

  // clog2 that never returns 0, so every derived width is a legal vector width.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned src_width(input int unsigned n_in, input int unsigned n_gates);
    return clog2_min1(max_u(n_in, n_gates));
  endfunction

  function automatic int unsigned cfg_width(input int unsigned src_w);
    return 3 + 2 * src_w;
  endfunction

  function automatic int unsigned score_width(input int unsigned g);
    return clog2_min1(g + 1);
  endfunction

  // Builds {op, src_a, src_b} right-aligned in 32 bits; callers keep the low cfg_width bits.
  function automatic logic [31:0] cfg_pack(input gate_op_e op, input int unsigned a,
                                           input int unsigned b, input int unsigned src_w);
    logic [31:0] mask;
    mask = (32'd1 << src_w) - 32'd1;
    return (32'(op) << (2 * src_w)) | ((a & mask) << src_w) | (b & mask);
  endfunction

endpackage

// File: rtl/gate_net_layer.sv
// One combinational layer of N_GATES two-input gates, each with its own config word.
module gate_net_layer
  import gate_net_pkg::*;
#(
  parameter int unsigned N_SRC   = 49,
  parameter int unsigned N_GATES = 24,
  parameter int unsigned SRC_W   = 6,
  parameter int unsigned CFG_W   = 15
) (
  input  logic [N_SRC-1:0]         src,
  input  logic [N_GATES*CFG_W-1:0] cfg,
  output logic [N_GATES-1:0]       dout
);

  localparam int unsigned PAD_W = 1 << SRC_W;

  // Zero padding makes every encodable source index legal; indices past the
  // real source width read 0.
  logic [PAD_W-1:0] src_pad;
  assign src_pad = PAD_W'(src);

  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    logic [CFG_W-1:0] word;
    gate_op_e         op;
    logic             a;
    logic             b;
    logic             y;

    assign word = cfg[g*CFG_W +: CFG_W];
    assign op   = gate_op_e'(word[CFG_W-1 -: 3]);
    assign a    = src_pad[word[2*SRC_W-1 -: SRC_W]];
    assign b    = src_pad[word[SRC_W-1:0]];

    // Apply the selected two-input function.
    always_comb begin
      y = 1'b0;
      case (op)
        OpConst0: y = 1'b0;
        OpConst1: y = 1'b1;
        OpAnd:    y = a & b;
        OpOr:     y = a | b;
        OpXor:    y = a ^ b;
        OpNand:   y = ~(a & b);
        OpNor:    y = ~(a | b);
        OpPassA:  y = a;
        default:  y = 1'b0;
      endcase
    end

    assign dout[g] = y;
  end

endmodule

// File: rtl/gate_net_infer_seq.sv
// Sequential gate-network classifier: one layer per clock from a programmable
// config table, then grouped popcount and argmax over a valid/ready stream.
module gate_net_infer_seq
  import gate_net_pkg::*;
#(
  parameter int unsigned N_IN     = 49,
  parameter int unsigned N_GATES  = 24,
  parameter int unsigned N_LAYERS = 2,
  parameter int unsigned N_CLASS  = 2,
  localparam int unsigned SRC_W   = src_width(N_IN, N_GATES),
  localparam int unsigned CFG_W   = cfg_width(SRC_W),
  localparam int unsigned ADDR_W  = clog2_min1(N_LAYERS * N_GATES),
  localparam int unsigned G       = N_GATES / N_CLASS,
  localparam int unsigned SC_W    = score_width(G),
  localparam int unsigned CLS_W   = clog2_min1(N_CLASS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  output logic [N_CLASS-1:0] out_onehot,
  output logic [SC_W-1:0]   out_score,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_err
);

  localparam int unsigned N_SRC = max_u(N_IN, N_GATES);
  localparam int unsigned N_CFG = N_LAYERS * N_GATES;
  localparam int unsigned LC_W  = clog2_min1(N_LAYERS);

  if (N_GATES % N_CLASS != 0) begin : g_chk_groups
    $fatal(1, "N_GATES must be a multiple of N_CLASS");
  end
  if (N_LAYERS < 1) begin : g_chk_layers
    $fatal(1, "N_LAYERS must be at least 1");
  end
  if (N_CLASS < 2) begin : g_chk_class
    $fatal(1, "N_CLASS must be at least 2");
  end

  gn_state_e            state_q, state_d;
  logic [LC_W-1:0]      lc_q, lc_d;
  logic [N_IN-1:0]      in_q, in_d;
  logic [N_GATES-1:0]   layer_q, layer_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [CLS_W-1:0]     out_class_q, out_class_d;
  logic [N_CLASS-1:0]   out_onehot_q, out_onehot_d;
  logic [SC_W-1:0]      out_score_q, out_score_d;
  logic                 cfg_err_q;

  logic [CFG_W-1:0]         cfg_mem [N_CFG];
  logic                     cfg_ok;
  logic [ADDR_W-1:0]        layer_base;
  logic [N_GATES*CFG_W-1:0] cfg_layer;
  logic [N_SRC-1:0]         layer_src;
  logic [N_GATES-1:0]       layer_out;

  logic [SC_W-1:0]  grp_cnt;
  logic [SC_W-1:0]  best_score;
  logic [CLS_W-1:0] best_cls;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_onehot = out_onehot_q;
  assign out_score  = out_score_q;
  assign cfg_err    = cfg_err_q;

  // Writes land only while idle; a write alongside an accepted sample is
  // visible to that sample because evaluation starts on the next edge.
  assign cfg_ok = (state_q == StIdle) && (32'(cfg_addr) < N_CFG);

  // Config table and write-reject pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CFG; i++) begin
        cfg_mem[i] <= '0;
      end
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we & ~cfg_ok;
      if (cfg_we && cfg_ok) begin
        cfg_mem[cfg_addr] <= cfg_data;
      end
    end
  end

  assign layer_base = ADDR_W'(lc_q * N_GATES);

  for (genvar g = 0; g < N_GATES; g++) begin : g_cfg_sel
    assign cfg_layer[g*CFG_W +: CFG_W] = cfg_mem[layer_base + ADDR_W'(g)];
  end

  // Layer 0 sees the captured sample; later layers see the previous layer,
  // zero-extended so wide indices read 0.
  assign layer_src = (lc_q == '0) ? N_SRC'(in_q) : N_SRC'(layer_q);

  gate_net_layer #(
    .N_SRC  (N_SRC),
    .N_GATES(N_GATES),
    .SRC_W  (SRC_W),
    .CFG_W  (CFG_W)
  ) u_layer (
    .src (layer_src),
    .cfg (cfg_layer),
    .dout(layer_out)
  );

  // Group popcount and argmax; strict compare keeps the lowest index on ties.
  always_comb begin
    grp_cnt    = '0;
    best_score = '0;
    best_cls   = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      grp_cnt = '0;
      for (int i = 0; i < G; i++) begin
        grp_cnt = grp_cnt + SC_W'(layer_q[c*G+i]);
      end
      if (grp_cnt > best_score) begin
        best_score = grp_cnt;
        best_cls   = CLS_W'(c);
      end
    end
  end

  // FSM next state, datapath capture and output register updates.
  always_comb begin
    state_d      = state_q;
    lc_d         = lc_q;
    in_d         = in_q;
    layer_d      = layer_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_onehot_d = out_onehot_q;
    out_score_d  = out_score_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          in_d    = in_bits;
          lc_d    = '0;
          state_d = StEval;
        end
      end
      StEval: begin
        layer_d = layer_out;
        lc_d    = lc_q + 1'b1;
        if (lc_q == LC_W'(N_LAYERS - 1)) begin
          state_d = StScore;
        end
      end
      StScore: begin
        out_valid_d  = 1'b1;
        out_class_d  = best_cls;
        out_onehot_d = N_CLASS'(1) << best_cls;
        out_score_d  = best_score;
        state_d      = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d == StIdle);
  end

  // State and datapath registers; in_ready stays low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      lc_q         <= '0;
      in_q         <= '0;
      layer_q      <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_onehot_q <= N_CLASS'(1);
      out_score_q  <= '0;
    end else begin
      state_q      <= state_d;
      lc_q         <= lc_d;
      in_q         <= in_d;
      layer_q      <= layer_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_onehot_q <= out_onehot_d;
      out_score_q  <= out_score_d;
    end
  end

endmodule

// File: tb/tb_gate_net_infer_seq.sv
// Directed bench for gate_net_infer_seq at default parameters (49/24/2/2).
module tb_gate_net_infer_seq;
  import gate_net_pkg::*;

  localparam int unsigned N_LAYERS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [48:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_class;
  logic [1:0]  out_onehot;
  logic [3:0]  out_score;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [14:0] cfg_data;
  logic        cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  gate_net_infer_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_onehot(out_onehot),
    .out_score (out_score),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] word(input gate_op_e op, input int unsigned a,
                                       input int unsigned b);
    logic [31:0] w;
    w = cfg_pack(op, a, b, 6);
    return w[14:0];
  endfunction

  task automatic cfg_write(input int unsigned addr, input gate_op_e op, input int unsigned a,
                           input int unsigned b);
    cfg_we   = 1'b1;
    cfg_addr = 6'(addr);
    cfg_data = word(op, a, b);
    tick();
    cfg_we = 1'b0;
    check("cfg_err_ok", cfg_err, 0);
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic send(input logic [48:0] bits);
    wait_ready();
    in_bits  = bits;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Checks latency, result fields and the output handshake.
  task automatic expect_result(input string tag, input int unsigned cls, input int unsigned sc);
    repeat (N_LAYERS) tick();
    check({tag, "_pre_valid"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_class"}, out_class, cls);
    check({tag, "_onehot"}, out_onehot, (cls == 0) ? 2'b01 : 2'b10);
    check({tag, "_score"}, out_score, sc);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_ready"}, in_ready, 1);
  endtask

  initial begin
    logic seen_valid;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bits = '0;
    out_ready = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_class", out_class, 0);
    check("rst_onehot", out_onehot, 2'b01);
    check("rst_score", out_score, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Default config is all CONST0.
    send(49'h0);
    expect_result("dflt", 0, 0);

    // Both layers pass gate g from source g.
    for (int g = 0; g < 24; g++) cfg_write(g, OpPassA, g, 0);
    for (int g = 0; g < 24; g++) cfg_write(24 + g, OpPassA, g, 0);
    send(49'h000FFF);
    expect_result("lo12", 0, 12);
    send(49'hFFF000);
    expect_result("hi12", 1, 12);

    // Tie goes to class 0.
    send(49'h3F03F);
    expect_result("tie", 0, 6);

    // Backpressure: outputs frozen, in_ready low.
    send(49'hFFF000);
    repeat (N_LAYERS + 1) tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_class", out_class, 1);
      check("hold_score", out_score, 12);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_valid", out_valid, 0);

    // Write during EVAL is rejected and must not affect this sample.
    send(49'h000FFF);
    cfg_we = 1'b1;
    cfg_addr = 6'd24;
    cfg_data = word(OpConst0, 0, 0);
    tick();
    cfg_we = 1'b0;
    check("eval_wr_err", cfg_err, 1);
    repeat (N_LAYERS - 1) tick();
    check("eval_wr_pre_valid", out_valid, 0);
    tick();
    check("eval_wr_valid", out_valid, 1);
    check("eval_wr_score", out_score, 12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Out-of-range address is rejected; the pulse lasts one cycle.
    cfg_we = 1'b1;
    cfg_addr = 6'd48;
    cfg_data = word(OpConst1, 0, 0);
    tick();
    cfg_we = 1'b0;
    check("oob_wr_err", cfg_err, 1);
    tick();
    check("oob_wr_err_clr", cfg_err, 0);
    send(49'h000FFF);
    expect_result("rerun_lo12", 0, 12);
    send(49'hFFF000);
    expect_result("rerun_hi12", 1, 12);

    // Mixed opcodes on layer 1 group 1 with layer-0 bits 0..3 set; g23 reads index 40,
    // which is past the layer width and must read 0 even though in_bits[40] is set.
    cfg_write(37, OpAnd, 0, 1);
    cfg_write(38, OpAnd, 0, 4);
    cfg_write(39, OpOr, 4, 5);
    cfg_write(40, OpOr, 3, 4);
    cfg_write(41, OpXor, 0, 1);
    cfg_write(42, OpXor, 0, 4);
    cfg_write(43, OpNand, 0, 1);
    cfg_write(44, OpNand, 4, 5);
    cfg_write(45, OpNor, 4, 5);
    cfg_write(46, OpNor, 0, 4);
    cfg_write(47, OpPassA, 40, 0);
    // Final write rides along with the accepted sample and must already apply.
    wait_ready();
    cfg_we = 1'b1;
    cfg_addr = 6'd36;
    cfg_data = word(OpConst1, 0, 0);
    in_bits = 49'h1000000000F;
    in_valid = 1'b1;
    tick();
    cfg_we = 1'b0;
    in_valid = 1'b0;
    check("same_cycle_wr_err", cfg_err, 0);
    expect_result("ops", 1, 6);

    // Reset mid-EVAL drops the sample and clears the config table.
    send(49'h000FFF);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_class", out_class, 0);
    check("mid_rst_onehot", out_onehot, 2'b01);
    check("mid_rst_score", out_score, 0);
    check("mid_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    check("rel_rst_in_ready", in_ready, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid === 1'b1) seen_valid = 1'b1;
    end
    check("dropped_sample", seen_valid, 0);
    check("after_rst_in_ready", in_ready, 1);
    send(49'h000FFF);
    expect_result("cleared_cfg", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
